alu_mc: RTL
===========

// Module: alu_mc
// PURPOSE
//  Multi-cycle, width-parametrised ALU for the accumulator datapath. Same unit/op encoding as the
//  combinational 8-bit ALU, plus: iterative shift-add multiplier with high-half select, bit-serial
//  shifter, start/busy/done handshake and an optional NZCV flag register. Driven by the core control FSM.
// PARAMETERS
//  W     8   datapath width; power of two, >= 4
//  SHW   $clog2(W)   shift-amount width; derived, do not override
// PORTS
//  clk_in       in   1     clock, all state on rising edge
//  rst_in       in   1     synchronous, active-high reset
//  start_in     in   1     request; accepted when busy_out==0
//  unit_sel_in  in   3     unit select, sampled on accept
//  op_sel_in    in   1     sub / high-half / right-shift select, sampled on accept
//  acc_in       in   W     operand A, sampled on accept
//  src_in       in   W     operand B (shift amount = src_in[SHW-1:0]), sampled on accept
//  busy_out     out  1     op in progress (state EXEC)
//  done_out     out  1     one-cycle pulse: alu_res_out/flags_out valid
//  alu_res_out  out  W     registered result, held until next done_out
//  flags_out    out  4     {N,Z,C,V}, registered with result
// BEHAVIOUR
//  - Reset: state IDLE, busy_out=0, done_out=0, alu_res_out=0, flags_out=0. Reset mid-op aborts; no done.
//  - FSM IDLE/EXEC/DONE. Accept = start_in && state!=EXEC; operands latched at accepting edge.
//    IDLE/DONE --accept, 1-cycle unit--> DONE; --accept, mul or shift amt>=2--> EXEC.
//    EXEC --last step--> DONE. DONE --no accept--> IDLE. start_in in EXEC ignored, no queuing.
//  - Back-to-back: accept allowed in the DONE cycle; done_out may be high on consecutive cycles.
//  - Latency (accepting edge -> edge that sets done_out): 1 for units 000,011-111 and shift amt 0/1;
//    amt for shift amt>=2; W for multiply.
//  - Units: 000 A+B (op0) / A+~B+1 (op1), mod 2^W.
//    001 unsigned A*B via W shift-add steps, 2W product; op0 -> low W bits, op1 -> high W bits.
//    010 shift A by one bit per cycle, zero fill; op0 left, op1 right logical; amt 0 -> A.
//    011 B; 100 A|B; 101 A^B; 110 A&B; 111 A (branch test).
//  - Flags (updated only on the edge that sets done_out): N=res[W-1]; Z=(res==0);
//    C: add = carry out, sub = no-borrow (A>=B unsigned), mul = (other half != 0),
//       shift = last bit shifted out (0 if amt 0), others 0;
//    V: add/sub two's-complement overflow, else 0.
//  - alu_res_out/flags_out change only on done edges; stable while busy.
// CONFIGURATION
//  ALU_FLAGS_EN defined: flag register and logic as above.
//  ALU_FLAGS_EN undefined: no flag logic; flags_out tied to 4'b0000; port list unchanged.
// TESTING (W=8, ALU_FLAGS_EN defined unless noted)
//  1 rst_in high 2 cycles mid-traffic -> busy_out=0, done_out=0, alu_res_out=0x00, flags_out=0.
//  2 add 0x7F+0x01 (000,op0) -> done 1 cycle later, res 0x80, NZCV=1001; sub 0x05-0x05 (op1)
//    back-to-back in DONE cycle -> next cycle done, res 0x00, NZCV=0110.
//  3 mul 0x0F*0x11 op0 -> busy 7 cycles, done 8 edges after accept, res 0xFF, C=0;
//    0xFF*0xFF op1 -> res 0xFE, C=1; start_in pulsed while busy -> ignored, result unchanged.
//  4 shift 0x81 amt 3 op1 -> done 3 edges after accept, res 0x10, C=0; amt 0 -> res 0x81, latency 1.
//  5 reset asserted 4 cycles into a multiply -> no done_out, IDLE; add accepted next cycle completes.
//  6 ALU_FLAGS_EN undefined, repeat 2 -> identical results, flags_out=0000 throughout.

Source files
------------

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU (add/sub, shift-add multiply, serial shift, logic ops); NZCV register only when ALU_FLAGS_EN is defined.
// Latency accept->done_out: 1 for single-cycle units and shift amt 0/1, amt for longer shifts, W for multiply.
// Backpressure: start_in is ignored while busy_out is high; a new op may be accepted in the done cycle.
module alu_mc #(
  parameter int W = 8
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         start_in,
  input  logic [2:0]   unit_sel_in,
  input  logic         op_sel_in,
  input  logic [W-1:0] acc_in,
  input  logic [W-1:0] src_in,
  output logic         busy_out,
  output logic         done_out,
  output logic [W-1:0] alu_res_out,
  output logic [3:0]   flags_out
);

  localparam int SHW = $clog2(W);
  localparam int RW  = SHW + 1;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t        state;
  logic [2:0]    unit_q;
  logic          op_q;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;     // operand B; low product half while multiplying
  logic [W-1:0]  hi_q;    // high product half, or the value being shifted
  logic [RW-1:0] rem_q;   // steps still to run, including the one in DONE

  logic          accept;
  logic [RW-1:0] rem_init;

  assign accept = start_in && (state != EXEC);

  always_comb begin
    rem_init = '0;
    if (unit_sel_in == 3'b001)
      rem_init = RW'(W);
    else if (unit_sel_in == 3'b010)
      rem_init = {1'b0, src_in[SHW-1:0]};
  end

  // One multiply / shift step from the working registers.
  logic [W:0]   mul_sum;
  logic [W-1:0] mul_hi_nx;
  logic [W-1:0] mul_lo_nx;
  logic [W-1:0] sh_nx;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (b_q[0] ? {1'b0, a_q} : '0);
    mul_hi_nx = mul_sum[W:1];
    mul_lo_nx = {mul_sum[0], b_q[W-1:1]};
    sh_nx     = op_q ? (hi_q >> 1) : (hi_q << 1);
  end

  // Final result, valid in the DONE cycle (includes the last step).
  logic [W-1:0] b_eff;
  logic [W-1:0] res_nx;

  always_comb begin
    b_eff  = op_q ? ~b_q : b_q;
    res_nx = a_q;
    case (unit_q)
      3'b000:  res_nx = a_q + b_eff + {{(W-1){1'b0}}, op_q};
      3'b001:  res_nx = op_q ? mul_hi_nx : mul_lo_nx;
      3'b010:  res_nx = (rem_q != '0) ? sh_nx : hi_q;
      3'b011:  res_nx = b_q;
      3'b100:  res_nx = a_q | b_q;
      3'b101:  res_nx = a_q ^ b_q;
      3'b110:  res_nx = a_q & b_q;
      default: res_nx = a_q;
    endcase
  end

`ifdef ALU_FLAGS_EN
  logic [W:0] add_full;
  logic       c_nx;
  logic       v_nx;
  logic [3:0] flags_nx;

  always_comb begin
    add_full = {1'b0, a_q} + {1'b0, b_eff} + {{W{1'b0}}, op_q};
    c_nx     = 1'b0;
    v_nx     = 1'b0;
    case (unit_q)
      3'b000: begin
        // carry out of A+~B+1 is the unsigned no-borrow indication
        c_nx = add_full[W];
        v_nx = (a_q[W-1] == b_eff[W-1]) && (add_full[W-1] != a_q[W-1]);
      end
      3'b001:  c_nx = op_q ? (mul_lo_nx != '0) : (mul_hi_nx != '0);
      3'b010:  c_nx = (rem_q != '0) && (op_q ? hi_q[0] : hi_q[W-1]);
      default: c_nx = 1'b0;
    endcase
    flags_nx = {res_nx[W-1], (res_nx == '0), c_nx, v_nx};
  end
`else
  assign flags_out = 4'b0000;
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state       <= IDLE;
      busy_out    <= 1'b0;
      done_out    <= 1'b0;
      alu_res_out <= '0;
      unit_q      <= '0;
      op_q        <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      hi_q        <= '0;
      rem_q       <= '0;
`ifdef ALU_FLAGS_EN
      flags_out   <= 4'b0000;
`endif
    end else begin
      done_out <= 1'b0;
      if (state == EXEC) begin
        if (unit_q == 3'b001) begin
          hi_q <= mul_hi_nx;
          b_q  <= mul_lo_nx;
        end else begin
          hi_q <= sh_nx;
        end
        rem_q <= rem_q - RW'(1);
        if (rem_q == RW'(2)) begin
          state    <= DONE;
          busy_out <= 1'b0;
        end
      end else begin
        if (state == DONE) begin
          done_out    <= 1'b1;
          alu_res_out <= res_nx;
`ifdef ALU_FLAGS_EN
          flags_out   <= flags_nx;
`endif
        end
        if (accept) begin
          unit_q <= unit_sel_in;
          op_q   <= op_sel_in;
          a_q    <= acc_in;
          b_q    <= src_in;
          hi_q   <= (unit_sel_in == 3'b010) ? acc_in : '0;
          rem_q  <= rem_init;
          if (rem_init >= RW'(2)) begin
            state    <= EXEC;
            busy_out <= 1'b1;
          end else begin
            state    <= DONE;
            busy_out <= 1'b0;
          end
        end else begin
          state    <= IDLE;
          busy_out <= 1'b0;
        end
      end
    end
  end

endmodule
